// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control FSM for the 8-bit datapath.
// Sequences FETCH/DECODE/EXEC/MEM/WB and drives the datapath selects.
// Ports: clk, reset (sync, active-high), start, opcode[2:0], alu_zero,
//   mem_ack in; mem_req, mem_we, addr_sel, ir_en, pc_en, pc_src[1:0],
//   alu_op, alu_src_b, reg_we, wb_sel, halted, fault, state[2:0] out.
// Optional MC_CTRL_PERF_EN: adds retired[15:0] instruction counter.
module mc_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] opcode,
  input  logic       alu_zero,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       ir_en,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       alu_op,
  output logic       alu_src_b,
  output logic       reg_we,
  output logic       wb_sel,
  output logic       halted,
  output logic       fault,
  output logic [2:0] state
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [15:0] retired
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } st_t;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_ADDI = 3'd2;
  localparam logic [2:0] OP_LW   = 3'd3;
  localparam logic [2:0] OP_SW   = 3'd4;
  localparam logic [2:0] OP_BEQ  = 3'd5;
  localparam logic [2:0] OP_JMP  = 3'd6;
  localparam logic [2:0] OP_HLT  = 3'd7;

  localparam logic [8:0] LIMIT = 9'(TIMEOUT_CYCLES);

  st_t        st_q;
  st_t        st_d;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic       tmo;

  // This req cycle without ack would be the LIMIT-th one.
  assign tmo = (TIMEOUT_CYCLES != 0) &&
               (({1'b0, cnt_q} + 9'd1) >= LIMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q  <= S_IDLE;
      cnt_q <= 8'd0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  // Counter clears on any state change, so entry to FETCH/MEM starts at 0.
  always_comb begin
    cnt_d = 8'd0;
    if (mem_req && !mem_ack && (st_d == st_q))
      cnt_d = cnt_q + 8'd1;
  end

  always_comb begin
    st_d      = st_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_en     = 1'b0;
    pc_en     = 1'b0;
    pc_src    = 2'b00;
    alu_op    = 1'b0;
    alu_src_b = 1'b0;
    reg_we    = 1'b0;
    wb_sel    = 1'b0;
    halted    = 1'b0;
    fault     = 1'b0;
    unique case (st_q)
      S_IDLE: begin
        if (start) st_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_en = 1'b1;
          pc_en = 1'b1;
          st_d  = S_DECODE;
        end else if (tmo) begin
          st_d = S_FAULT;
        end
      end
      S_DECODE: begin
        unique case (opcode)
          OP_JMP: begin
            pc_en  = 1'b1;
            pc_src = 2'b10;
            st_d   = S_FETCH;
          end
          OP_HLT:  st_d = S_HALT;
          default: st_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        unique case (opcode)
          OP_ADD, OP_SUB: begin
            alu_op = opcode[0];
            st_d   = S_WB;
          end
          OP_ADDI: begin
            alu_src_b = 1'b1;
            st_d      = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_src_b = 1'b1;
            st_d      = S_MEM;
          end
          OP_BEQ: begin
            alu_op = 1'b1;
            if (alu_zero) begin
              pc_en  = 1'b1;
              pc_src = 2'b01;
            end
            st_d = S_FETCH;
          end
          default: st_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (opcode == OP_SW);
        if (mem_ack) begin
          st_d = (opcode == OP_SW) ? S_FETCH : S_WB;
        end else if (tmo) begin
          st_d = S_FAULT;
        end
      end
      S_WB: begin
        reg_we = 1'b1;
        wb_sel = (opcode == OP_LW);
        st_d   = S_FETCH;
      end
      S_HALT:  halted = 1'b1;
      S_FAULT: fault  = 1'b1;
    endcase
  end

  assign state = st_q;

`ifdef MC_CTRL_PERF_EN
  logic [15:0] ret_q;

  // An instruction retires when control returns to FETCH.
  always_ff @(posedge clk) begin
    if (reset)
      ret_q <= 16'd0;
    else if ((st_d == S_FETCH) &&
             (st_q inside {S_DECODE, S_EXEC, S_MEM, S_WB}))
      ret_q <= ret_q + 16'd1;
  end

  assign retired = ret_q;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed + randomized instruction streams for mc_ctrl,
// checked per cycle against an instruction-level phase model.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [2:0] opcode = 3'd0;
  logic       alu_zero = 1'b0;
  logic       mem_ack = 1'b0;
  logic       mem_req, mem_we, addr_sel, ir_en, pc_en;
  logic [1:0] pc_src;
  logic       alu_op, alu_src_b, reg_we, wb_sel, halted, fault;
  logic [2:0] state;
`ifdef MC_CTRL_PERF_EN
  logic [15:0] retired;
`endif

  always #5 clk = ~clk;

  mc_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode),
    .alu_zero(alu_zero), .mem_ack(mem_ack), .mem_req(mem_req),
    .mem_we(mem_we), .addr_sel(addr_sel), .ir_en(ir_en),
    .pc_en(pc_en), .pc_src(pc_src), .alu_op(alu_op),
    .alu_src_b(alu_src_b), .reg_we(reg_we), .wb_sel(wb_sel),
    .halted(halted), .fault(fault), .state(state)
`ifdef MC_CTRL_PERF_EN
    , .retired(retired)
`endif
  );

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, ADDI = 3'd2;
  localparam logic [2:0] LW = 3'd3, SW = 3'd4, BEQ = 3'd5;
  localparam logic [2:0] JMP = 3'd6, HLT = 3'd7;

  typedef struct packed {
    logic       req, we, asel, ir, pcen;
    logic [1:0] src;
    logic       aluop, srcb, regwe, wbsel, halted, fault;
    logic [2:0] st;
  } ov_t;

  ov_t obs;
  assign obs = {mem_req, mem_we, addr_sel, ir_en, pc_en, pc_src,
                alu_op, alu_src_b, reg_we, wb_sel, halted, fault, state};

  int total = 0;
  int passed = 0;
  int model_ret = 0;

  task automatic step(input string tag, input ov_t e, input logic ack);
    mem_ack = ack;
    @(negedge clk);
    total++;
    assert (obs === e) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, e);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ret(input string tag);
`ifdef MC_CTRL_PERF_EN
    @(negedge clk);
    total++;
    assert (retired === 16'(model_ret)) passed++;
    else $error("FAIL %s: retired %0d expected %0d", tag, retired,
                model_ret);
    @(posedge clk);
    #1;
`endif
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'($urandom);
    mem_ack = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    start = 1'b0;
    model_ret = 0;
  endtask

  // IDLE with stray ack (ignored), then start.
  task automatic idle_start();
    ov_t e;
    e = '0;
    start = 1'b0;
    step("idle", e, 1'b1);
    start = 1'b1;
    step("idle_start", e, 1'($urandom));
  endtask

  // Request phase: n cycles without ack. Four of them means timeout.
  task automatic req_phase(input string tag, input ov_t e,
                           input int n, output bit flt);
    flt = 1'b0;
    for (int i = 0; i < n && i < 4; i++) step({tag, "_wait"}, e, 1'b0);
    if (n >= 4) flt = 1'b1;
  endtask

  // One instruction from FETCH to the next FETCH entry.
  // stuck=1 when it ended in HALT or FAULT.
  task automatic run_instr(input logic [2:0] op, input logic z,
                           input int fw, input int mw,
                           output bit stuck);
    ov_t e;
    bit  flt;
    stuck = 1'b0;
    opcode = 3'($urandom);
    alu_zero = 1'($urandom);
    start = 1'($urandom);
    e = '0; e.st = 3'd1; e.req = 1'b1;
    req_phase("fetch", e, fw, flt);
    if (flt) begin stuck = 1'b1; return; end
    e.ir = 1'b1; e.pcen = 1'b1;
    step("fetch_ack", e, 1'b1);
    opcode = op;
    alu_zero = z;
    e = '0; e.st = 3'd2;
    if (op == JMP) begin
      e.pcen = 1'b1; e.src = 2'b10;
      step("dec_jmp", e, 1'($urandom));
      model_ret++;
      return;
    end
    step("decode", e, 1'($urandom));
    if (op == HLT) begin stuck = 1'b1; return; end
    e = '0; e.st = 3'd3;
    case (op)
      ADD, SUB: e.aluop = op[0];
      ADDI, LW, SW: e.srcb = 1'b1;
      default: begin
        e.aluop = 1'b1;
        if (z) begin e.pcen = 1'b1; e.src = 2'b01; end
      end
    endcase
    step("exec", e, 1'($urandom));
    if (op == LW || op == SW) begin
      e = '0; e.st = 3'd4; e.req = 1'b1; e.asel = 1'b1;
      e.we = (op == SW);
      req_phase("mem", e, mw, flt);
      if (flt) begin stuck = 1'b1; return; end
      step("mem_ack", e, 1'b1);
    end
    if (op != BEQ && op != SW) begin
      e = '0; e.st = 3'd5; e.regwe = 1'b1; e.wbsel = (op == LW);
      step("wb", e, 1'($urandom));
    end
    model_ret++;
  endtask

  task automatic sticky(input string tag, input ov_t e, input int n);
    for (int i = 0; i < n; i++) begin
      start = 1'b1;
      opcode = 3'($urandom);
      alu_zero = 1'($urandom);
      step(tag, e, 1'($urandom));
    end
  endtask

  initial begin
    ov_t e;
    bit  s;
    logic [2:0] op;

    do_reset();
    chk_ret("ret_reset");
    idle_start();
    run_instr(ADD, 1'b0, 0, 0, s);
    run_instr(ADDI, 1'b1, 0, 0, s);
    run_instr(LW, 1'b0, 0, 3, s);
    run_instr(BEQ, 1'b1, 0, 0, s);
    run_instr(BEQ, 1'b0, 0, 0, s);
    run_instr(SUB, 1'b1, 3, 0, s);
    run_instr(SW, 1'b0, 1, 3, s);
    chk_ret("ret_directed");

    for (int k = 0; k < 40; k++) begin
      op = 3'($urandom_range(0, 6));
      run_instr(op, 1'($urandom), $urandom_range(0, 3),
                $urandom_range(0, 3), s);
    end
    chk_ret("ret_random");

    // FETCH timeout: four req cycles, then sticky FAULT.
    run_instr(ADD, 1'b0, 4, 0, s);
    e = '0; e.fault = 1'b1; e.st = 3'd7;
    sticky("fault_fetch", e, 3);
    chk_ret("ret_fault_frozen");
    do_reset();
    idle_start();

    // MEM timeout.
    run_instr(LW, 1'b0, 0, 4, s);
    sticky("fault_mem", e, 2);
    do_reset();
    idle_start();

    // JMP then HLT, HALT sticky, start ignored.
    run_instr(JMP, 1'b0, 0, 0, s);
    run_instr(HLT, 1'b0, 0, 0, s);
    e = '0; e.halted = 1'b1; e.st = 3'd6;
    sticky("halt", e, 3);
    chk_ret("ret_halt_frozen");
    do_reset();
    e = '0;
    step("after_halt_reset", e, 1'b1);

    // Reset during MEM of SW.
    idle_start();
    run_instr(ADDI, 1'b0, 0, 0, s);
    start = 1'b0;
    opcode = 3'($urandom);
    e = '0; e.st = 3'd1; e.req = 1'b1; e.ir = 1'b1; e.pcen = 1'b1;
    step("sw_fetch", e, 1'b1);
    opcode = SW;
    e = '0; e.st = 3'd2;
    step("sw_decode", e, 1'b0);
    e = '0; e.st = 3'd3; e.srcb = 1'b1;
    step("sw_exec", e, 1'b0);
    e = '0; e.st = 3'd4; e.req = 1'b1; e.asel = 1'b1; e.we = 1'b1;
    step("sw_mem", e, 1'b0);
    do_reset();
    e = '0;
    step("mem_reset_idle", e, 1'b0);
    chk_ret("ret_after_reset");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle control FSM for the 8-bit datapath. Sequences fetch, decode, execute, memory and writeback.
- Drives the datapath selects:
  - PC source.
  - ALU B-operand source, which includes the 5-bit to 8-bit sign-extended immediate.
  - Register write enable.
  - Memory request with a req/ack handshake.
- Sits between the instruction register / ALU flags and the datapath muxes. Holds no data, only control state.

Parameters:
- TIMEOUT_CYCLES, 15: cycles to wait for mem_ack before entering FAULT. 0 disables the timeout. Legal range 0..255.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  leave IDLE and begin fetching.
- opcode  input  3  IR[7:5], stable after ir_en.
- alu_zero  input  1  ALU result==0 flag.
- mem_ack  input  1  memory transfer complete; may be asserted in the same cycle as mem_req.
- mem_req  output  1  memory access request.
- mem_we  output  1  store when 1 (valid only with mem_req).
- addr_sel  output  1  0 = PC, 1 = ALU result.
- ir_en  output  1  load IR from memory data.
- pc_en  output  1  update PC.
- pc_src  output  2  00 = PC+1, 01 = PC+signext(imm5), 10 = zero-extended IR[4:0].
- alu_op  output  1  0 = add, 1 = sub.
- alu_src_b  output  1  0 = register rt, 1 = signext(imm5).
- reg_we  output  1  register file write.
- wb_sel  output  1  0 = ALU result, 1 = memory data.
- halted  output  1  in HALT.
- fault  output  1  in FAULT (memory timeout).
- state  output  3  current state encoding, for debug.

Behaviour:
- Reset (synchronous, active-high, clk and reset as named above):
  - state=IDLE, all outputs 0, timeout counter=0.
  - Reset mid-operation aborts any pending request; mem_req drops the next cycle.
- Registered: the state register and the timeout counter. Outputs are combinational decodes of state, opcode, mem_ack and alu_zero.
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, FAULT=7.
- Opcode map: 000 ADD, 001 SUB, 010 ADDI, 011 LW, 100 SW, 101 BEQ, 110 JMP, 111 HLT.
- IDLE: start=1 -> FETCH.
- FETCH:
  - mem_req=1, addr_sel=0.
  - On mem_ack: ir_en=1, pc_en=1, pc_src=00, -> DECODE.
- DECODE (1 cycle):
  - JMP: pc_en=1, pc_src=10, -> FETCH.
  - HLT -> HALT.
  - All other opcodes -> EXEC.
- EXEC:
  - ADD/SUB: alu_src_b=0, alu_op=opcode[0], -> WB.
  - ADDI/LW/SW: alu_src_b=1, alu_op=0. ADDI -> WB; LW/SW -> MEM.
  - BEQ: alu_src_b=0, alu_op=1. If alu_zero: pc_en=1, pc_src=01. -> FETCH.
- MEM:
  - mem_req=1, addr_sel=1, mem_we=(opcode==SW).
  - On mem_ack: SW -> FETCH, LW -> WB.
- WB: reg_we=1, wb_sel=(opcode==LW), -> FETCH.
- Latency with zero-wait memory:
  - ADD/SUB/ADDI/LW: 4 / 4 / 4 / 5 cycles.
  - SW: 4 cycles. BEQ: 3 cycles. JMP: 2 cycles.
- Handshake rules:
  - mem_req is held high until the cycle mem_ack is sampled high. That is the transfer cycle; the FSM leaves the state at the next edge.
  - mem_ack while mem_req=0 is ignored.
- Timeout:
  - The counter clears on entry to FETCH/MEM and increments on each req cycle without ack.
  - When the counter reaches TIMEOUT_CYCLES without ack -> FAULT.
  - Ack in the same cycle the count reaches the limit: the ack wins.
- HALT and FAULT are sticky. Only reset leaves them. All strobes are 0; halted=1 or fault=1 respectively.
- start is ignored outside IDLE.
- PC arithmetic (wrap modulo 256) is done in the datapath; the controller only selects the source.

Optional Feature:
- Macro: MC_CTRL_PERF_EN.
- Defined:
  - Adds output port retired [15:0]. It counts instructions completed, incremented on every transition into FETCH from DECODE, EXEC, MEM or WB.
  - Wraps at 0xFFFF -> 0x0000, cleared by reset, frozen in HALT/FAULT.
- Not defined: the port is absent and no counter logic is generated.

Test Plan:
- Reset then start=1 with ack tied 1; opcode stream ADD, ADDI (imm5=10101 -> ALU B operand 0xF5) -> reg_we pulses at cycles 4 and 8. alu_src_b=0 in the first EXEC, 1 in the second.
- LW with ack delayed 3 cycles in MEM -> mem_req stays high for 4 cycles, addr_sel=1, mem_we=0. WB with wb_sel=1 follows; total 8 cycles.
- BEQ with alu_zero=1 -> pc_en=1 and pc_src=01 in EXEC. Repeat with alu_zero=0 -> pc_en=0 in EXEC; the next FETCH follows immediately.
- TIMEOUT_CYCLES=4, ack held 0 in FETCH -> fault=1 and state=7 after 4 req cycles; remains until reset. Same setup with ack arriving on the 4th cycle -> no fault.
- JMP then HLT -> pc_src=10 for 1 cycle, then halted=1. Asserting start afterwards has no effect; reset -> state=0 with all outputs 0.
- Assert reset during MEM of SW -> mem_req=0 and state=IDLE the next cycle. With MC_CTRL_PERF_EN defined, retired=0.
